fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Front end of the dual-issue pipeline, directly upstream of the decode stage and the hazard unit.
- Generates the fetch PC and issues 8-byte instruction-pair requests to the I-cache over a valid/ready request channel plus a response-valid channel.
- Buffers returned pairs in a small queue and drives the decode pipeline register (enableD, InstrD1/2, PCD1/2).
- Consumes StallF, StallD, FlushD and the execute-stage redirects PCSrcE1/PCSrcE2.

Parameters:
ENTRY, 64'h0, reset fetch PC; must be 8-byte aligned.
XLEN, 64, address width.
BUF_DEPTH, 4, instruction-pair queue entries; power of two, at least 2.

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-high reset
StallF  input  1  hazard: block launch of new requests
StallD  input  1  hazard: hold the decode register
FlushD  input  1  hazard: invalidate the decode register
PCSrcE1  input  1  redirect from lane 1 (older)
PCSrcE2  input  1  redirect from lane 2
PCTargetE1  input  XLEN  lane 1 target, 4-byte aligned
PCTargetE2  input  XLEN  lane 2 target, 4-byte aligned
ic_req_valid  output  1  request valid
ic_req_addr  output  XLEN  request address, 8-byte aligned
ic_req_ready  input  1  cache accepts the request
ic_resp_valid  input  1  response data valid
ic_resp_data  input  64  [31:0] word at addr, [63:32] word at addr+4
enableD  output  1  decode register holds a valid pair
InstrD1  output  32  lane 1 instruction
InstrD2  output  32  lane 2 instruction
PCD1  output  XLEN  lane 1 PC
PCD2  output  XLEN  lane 2 PC, always PCD1+4

Behaviour:
- Reset (asynchronous): fetch_pc = ENTRY, FSM = IDLE, queue empty, drop_pending = 0.
- Reset values of outputs: ic_req_valid = 0, ic_req_addr = ENTRY & ~7, enableD = 0, InstrD1 = InstrD2 = 32'h00000013, PCD1 = 0, PCD2 = 4.
- At most one outstanding cache request.
- FSM states:
  - IDLE: go to REQ when the queue has a free slot (counting the in-flight pair) and StallF = 0.
  - REQ: ic_req_valid = 1, ic_req_addr = {fetch_pc[XLEN-1:3], 3'b0}. Valid and address are held stable until ic_req_ready; then go to WAIT.
  - WAIT: on ic_resp_valid, push {fetch_pc, data}, set fetch_pc = (fetch_pc & ~7) + 8, go to IDLE.
  - DROP: on ic_resp_valid, discard the data, go to IDLE.
- Redirect = PCSrcE1 | PCSrcE2. Target selection: PCTargetE1 when PCSrcE1, else PCTargetE2. Lane 1 wins when both are asserted.
- On redirect:
  - Set fetch_pc = target and empty the queue.
  - In IDLE: stay in IDLE.
  - In REQ without ic_req_ready: the address must not change; set drop_pending. On acceptance, go to DROP instead of WAIT.
  - In REQ with ic_req_ready in the same cycle: go to DROP.
  - In WAIT: go to DROP. If ic_resp_valid arrives in the same cycle, discard it and go to IDLE.
  - In DROP: stay in DROP.
- Unaligned pair (entry pc[2] = 1):
  - PCD1 = pc, InstrD1 = data[63:32].
  - InstrD2 = 32'h00000013 (NOP), PCD2 = pc + 4.
  - The next fetch uses (pc & ~7) + 8.
- Decode register priority: reset, then FlushD, then StallD.
  - FlushD: enableD = 0 and the instructions become NOPs. PC fields are don't-care.
  - StallD: hold all decode outputs.
  - Otherwise: if the queue is non-empty, pop the head into the register with enableD = 1; else enableD = 0 with NOPs.
- No bypass. A response seen in cycle N gives enableD = 1 after the second rising edge, at the earliest in cycle N+2.
- Queue full: no request is launched. Push and pop in the same cycle are legal when full or empty. Pointers wrap modulo BUF_DEPTH.
- StallF blocks only the IDLE to REQ transition. An in-flight request completes regardless of StallF.

Decomposition:
- Shared package fetch_pkg:
  - fetch_state_t enum {IDLE, REQ, WAIT, DROP}
  - NOP_INSTR = 32'h00000013
  - fetch_entry_t struct {pc, data}
- One sub-module, fetch_queue: a parameterised synchronous FIFO with push, pop, flush, full, empty and count.

Test Plan:
- Reset release with ENTRY = 0x1000, ready = 1, one-cycle response latency, data 0x00A00513_00100093 -> ic_req_addr = 0x1000; two edges later enableD = 1, InstrD1 = 0x00100093, InstrD2 = 0x00A00513, PCD1 = 0x1000; next request at 0x1008.
- ic_req_ready held 0 for 5 cycles -> ic_req_valid stays 1 and ic_req_addr stays 0x1000 throughout.
- StallD held high with responses streaming -> queue fills to BUF_DEPTH = 4 and ic_req_valid stays 0; releasing StallD pops pairs 0x1000, 0x1008, ... in order with no loss.
- PCSrcE1 = PCSrcE2 = 1, PCTargetE1 = 0x2004, PCTargetE2 = 0x3000, issued in WAIT -> pending response discarded, queue emptied; next ic_req_addr = 0x2000; decode gets PCD1 = 0x2004, InstrD1 = upper word, InstrD2 = 0x00000013; following fetch at 0x2008.
- Redirect in the same cycle as ic_resp_valid -> data is not enqueued, FSM returns to IDLE, and the next request uses the target.
- FlushD and StallD high together -> enableD = 0 next cycle; reset asserted in WAIT -> outputs return to their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the fetch front end: FSM encoding, queue entry layout, NOP encoding.
package fetch_pkg;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int          PC_W      = 64;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [63:0]     data;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetched instruction pairs; push and pop may coincide even when full.
module fetch_queue #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [7:0]
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  T                       din_i,
    output T                       dout_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);

    T               mem_q [DEPTH];
    logic [AW-1:0]  rd_q, wr_q;
    logic [AW:0]    cnt_q;
    logic           do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign count_o = cnt_q;
    assign dout_o  = mem_q[rd_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    // Storage needs no reset; occupancy is tracked by the counters above.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_q] <= din_i;
    end
endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: one outstanding I-cache pair request, redirect/drop handling,
// pair queue and the decode pipeline register.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [63:0] ENTRY     = 64'h0,
    parameter int          XLEN      = 64,
    parameter int          BUF_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            StallF,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic            PCSrcE1,
    input  logic            PCSrcE2,
    input  logic [XLEN-1:0] PCTargetE1,
    input  logic [XLEN-1:0] PCTargetE2,
    output logic            ic_req_valid,
    output logic [XLEN-1:0] ic_req_addr,
    input  logic            ic_req_ready,
    input  logic            ic_resp_valid,
    input  logic [63:0]     ic_resp_data,
    output logic            enableD,
    output logic [31:0]     InstrD1,
    output logic [31:0]     InstrD2,
    output logic [XLEN-1:0] PCD1,
    output logic [XLEN-1:0] PCD2
);
    localparam int             CW      = $clog2(BUF_DEPTH) + 1;
    localparam logic [CW-1:0]  DEPTH_C = CW'(BUF_DEPTH);
    localparam logic [XLEN-1:0] ENTRY_A = XLEN'(ENTRY) & ~XLEN'(7);

    fetch_state_t    state_q;
    logic [XLEN-1:0] fetch_pc_q, req_addr_q, target, head_pc;
    logic            req_valid_q, drop_pending_q, redirect;
    logic            q_push, q_pop, q_full, q_empty;
    logic [CW-1:0]   q_count;
    fetch_entry_t    push_entry, head;

    assign redirect = PCSrcE1 | PCSrcE2;
    assign target   = PCSrcE1 ? PCTargetE1 : PCTargetE2;

    assign ic_req_valid = req_valid_q;
    assign ic_req_addr  = req_addr_q;

    assign push_entry.pc   = PC_W'(fetch_pc_q);
    assign push_entry.data = ic_resp_data;
    assign q_push  = (state_q == WAIT) && ic_resp_valid && !redirect && (!q_full || q_pop);
    assign q_pop   = !FlushD && !StallD && !q_empty;
    assign head_pc = head.pc[XLEN-1:0];

    fetch_queue #(.DEPTH(BUF_DEPTH), .T(fetch_entry_t)) u_queue (
        .clk     (clk),
        .rst     (reset),
        .push_i  (q_push),
        .pop_i   (q_pop),
        .flush_i (redirect),
        .din_i   (push_entry),
        .dout_o  (head),
        .full_o  (q_full),
        .empty_o (q_empty),
        .count_o (q_count)
    );

    // Redirect always retargets fetch_pc; the per-state logic only decides what to do with the bus.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            fetch_pc_q     <= XLEN'(ENTRY);
            drop_pending_q <= 1'b0;
            req_valid_q    <= 1'b0;
            req_addr_q     <= ENTRY_A;
        end else begin
            if (redirect) fetch_pc_q <= target;
            case (state_q)
                IDLE: begin
                    if (!redirect && !StallF && (q_count < DEPTH_C)) begin
                        state_q     <= REQ;
                        req_valid_q <= 1'b1;
                        req_addr_q  <= {fetch_pc_q[XLEN-1:3], 3'b000};
                    end
                end
                REQ: begin
                    if (ic_req_ready) begin
                        req_valid_q    <= 1'b0;
                        drop_pending_q <= 1'b0;
                        state_q        <= (redirect || drop_pending_q) ? DROP : WAIT;
                    end else if (redirect) begin
                        drop_pending_q <= 1'b1;
                    end
                end
                WAIT: begin
                    if (redirect) begin
                        state_q <= ic_resp_valid ? IDLE : DROP;
                    end else if (ic_resp_valid) begin
                        fetch_pc_q <= {fetch_pc_q[XLEN-1:3], 3'b000} + XLEN'(8);
                        state_q    <= IDLE;
                    end
                end
                DROP: begin
                    if (ic_resp_valid) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enableD <= 1'b0;
            InstrD1 <= NOP_INSTR;
            InstrD2 <= NOP_INSTR;
            PCD1    <= '0;
            PCD2    <= XLEN'(4);
        end else if (FlushD) begin
            enableD <= 1'b0;
            InstrD1 <= NOP_INSTR;
            InstrD2 <= NOP_INSTR;
        end else if (!StallD) begin
            if (!q_empty) begin
                // A pair entered at pc[2]=1 carries only its upper word as a useful instruction.
                enableD <= 1'b1;
                InstrD1 <= head_pc[2] ? head.data[63:32] : head.data[31:0];
                InstrD2 <= head_pc[2] ? NOP_INSTR : head.data[63:32];
                PCD1    <= head_pc;
                PCD2    <= head_pc + XLEN'(4);
            end else begin
                enableD <= 1'b0;
                InstrD1 <= NOP_INSTR;
                InstrD2 <= NOP_INSTR;
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: I-cache model feeding an expected-pair scoreboard.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam logic [63:0] ENTRY = 64'h1000;

    logic        clk = 1'b0;
    logic        reset, StallF, StallD, FlushD, PCSrcE1, PCSrcE2;
    logic [63:0] PCTargetE1, PCTargetE2;
    logic        ic_req_valid, ic_req_ready, ic_resp_valid, enableD;
    logic [63:0] ic_req_addr, ic_resp_data, PCD1, PCD2;
    logic [31:0] InstrD1, InstrD2;

    always #5 clk = ~clk;

    fetch_unit #(.ENTRY(ENTRY), .XLEN(64), .BUF_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .PCSrcE1(PCSrcE1), .PCSrcE2(PCSrcE2), .PCTargetE1(PCTargetE1), .PCTargetE2(PCTargetE2),
        .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_req_ready),
        .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
        .enableD(enableD), .InstrD1(InstrD1), .InstrD2(InstrD2), .PCD1(PCD1), .PCD2(PCD2)
    );

    typedef struct packed {
        logic [63:0] pc1;
        logic [31:0] i1;
        logic [31:0] i2;
        logic [63:0] pc2;
    } dec_t;

    dec_t exp_q[$], obs_q[$];
    dec_t o, e;
    int   n_cmp = 0, n_bad = 0;
    int   lat = 1, sb_skip = 0;
    bit   next_unaligned = 0;

    function automatic logic [63:0] mem_data(input logic [63:0] a);
        if (a == 64'h1000) return 64'h00A00513_00100093;
        return {32'hB000_0000 ^ a[31:0], 32'hA000_0000 ^ a[31:0]};
    endfunction

    // I-cache model: accepts on valid&ready, answers lat cycles later, records expected decode pair.
    initial begin
        int          cnt;
        logic        acc;
        logic [63:0] a_smp, addr, d;
        cnt = 0; addr = '0; ic_resp_valid = 1'b0; ic_resp_data = '0;
        forever begin
            @(posedge clk);
            acc   = ic_req_valid && ic_req_ready && !reset;
            a_smp = ic_req_addr;
            #1;
            ic_resp_valid = 1'b0;
            if (reset) cnt = 0;
            else begin
                if (acc) begin addr = a_smp; cnt = lat; end
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        d = mem_data(addr);
                        ic_resp_data  = d;
                        ic_resp_valid = 1'b1;
                        if (sb_skip > 0) sb_skip--;
                        else begin
                            if (next_unaligned) exp_q.push_back(dec_t'{addr + 64'd4, d[63:32], NOP_INSTR, addr + 64'd8});
                            else                exp_q.push_back(dec_t'{addr, d[31:0], d[63:32], addr + 64'd4});
                            next_unaligned = 0;
                        end
                    end
                end
            end
        end
    end

    // Decode monitor: records every pair loaded into the decode register.
    initial begin
        logic ld;
        forever begin
            @(posedge clk);
            ld = !StallD && !FlushD && !reset;
            @(negedge clk);
            if (ld && enableD && !reset) obs_q.push_back(dec_t'{PCD1, InstrD1, InstrD2, PCD2});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected bench to finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic do_reset(input logic stall_d, input logic rdy, input int l);
        reset = 1'b1; StallF = 1'b0; StallD = stall_d; FlushD = 1'b0;
        PCSrcE1 = 1'b0; PCSrcE2 = 1'b0; PCTargetE1 = '0; PCTargetE2 = '0;
        ic_req_ready = rdy; lat = l; sb_skip = 0; next_unaligned = 0;
        tick(); tick();
        exp_q.delete(); obs_q.delete();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        tick(); tick();
        n_cmp++; if (ic_req_valid !== 1'b0 || ic_req_addr !== 64'h1000) begin n_bad++;
            $display("FAIL reset_req: valid=%b addr=%h, expected 0 / 1000", ic_req_valid, ic_req_addr); end
        n_cmp++; if (enableD !== 1'b0 || InstrD1 !== NOP_INSTR || InstrD2 !== NOP_INSTR) begin n_bad++;
            $display("FAIL reset_dec: en=%b i1=%h i2=%h, expected 0 / 00000013 / 00000013", enableD, InstrD1, InstrD2); end
        n_cmp++; if (PCD1 !== 64'h0 || PCD2 !== 64'h4) begin n_bad++;
            $display("FAIL reset_pc: pcd1=%h pcd2=%h, expected 0 / 4", PCD1, PCD2); end
    endtask

    task automatic test_first_fetch();
        do_reset(1'b0, 1'b1, 1);
        tick();
        n_cmp++; if (ic_req_valid !== 1'b1 || ic_req_addr !== 64'h1000) begin n_bad++;
            $display("FAIL first_req: valid=%b addr=%h, expected 1 / 1000", ic_req_valid, ic_req_addr); end
        tick(); tick();
        n_cmp++; if (enableD !== 1'b0) begin n_bad++;
            $display("FAIL no_bypass: enableD=%b one edge after response, expected 0", enableD); end
        tick();
        n_cmp++; if (enableD !== 1'b1 || InstrD1 !== 32'h00100093 || InstrD2 !== 32'h00A00513 || PCD1 !== 64'h1000 || PCD2 !== 64'h1004) begin n_bad++;
            $display("FAIL first_dec: en=%b i1=%h i2=%h pcd1=%h pcd2=%h, expected 1 00100093 00A00513 1000 1004", enableD, InstrD1, InstrD2, PCD1, PCD2); end
        n_cmp++; if (ic_req_valid !== 1'b1 || ic_req_addr !== 64'h1008) begin n_bad++;
            $display("FAIL second_req: valid=%b addr=%h, expected 1 / 1008", ic_req_valid, ic_req_addr); end
        repeat (12) tick();
        ic_req_ready = 1'b0;
        repeat (12) tick();
        n_cmp++; if (obs_q.size() != exp_q.size() || exp_q.size() < 3) begin n_bad++;
            $display("FAIL first_stream_count: got %0d pairs, expected %0d (at least 3)", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
            if (o !== e) begin n_bad++;
                $display("FAIL first_stream_pair: got %h %h %h %h, expected %h %h %h %h", o.pc1, o.i1, o.i2, o.pc2, e.pc1, e.i1, e.i2, e.pc2); end
        end
    endtask

    task automatic test_ready_hold();
        int bad = 0;
        do_reset(1'b0, 1'b0, 1);
        tick();
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (ic_req_valid !== 1'b1 || ic_req_addr !== 64'h1000) begin n_bad++; bad++;
                $display("FAIL ready_hold cycle %0d: valid=%b addr=%h, expected 1 / 1000", i, ic_req_valid, ic_req_addr); end
            tick();
        end
        ic_req_ready = 1'b1;
        repeat (10) tick();
        ic_req_ready = 1'b0;
        repeat (12) tick();
        n_cmp++; if (obs_q.size() != exp_q.size() || exp_q.size() == 0) begin n_bad++;
            $display("FAIL hold_stream_count: got %0d pairs, expected %0d (nonzero)", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
            if (o !== e) begin n_bad++;
                $display("FAIL hold_stream_pair: got %h %h %h %h, expected %h %h %h %h", o.pc1, o.i1, o.i2, o.pc2, e.pc1, e.i1, e.i2, e.pc2); end
        end
    endtask

    task automatic test_stall_fill();
        int k = 0;
        do_reset(1'b1, 1'b1, 1);
        while (exp_q.size() < 4 && k < 60) begin tick(); k++; end
        n_cmp++; if (exp_q.size() < 4) begin n_bad++;
            $display("FAIL fill_timeout: got %0d responses, expected 4 within 60 cycles", exp_q.size()); end
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++; if (ic_req_valid !== 1'b0) begin n_bad++;
                $display("FAIL full_no_req cycle %0d: valid=%b, expected 0", i, ic_req_valid); end
        end
        n_cmp++; if (exp_q.size() != 4 || enableD !== 1'b0) begin n_bad++;
            $display("FAIL full_depth: responses=%0d enableD=%b, expected 4 / 0", exp_q.size(), enableD); end
        StallD = 1'b0;
        repeat (8) tick();
        ic_req_ready = 1'b0;
        repeat (12) tick();
        n_cmp++; if (obs_q.size() != exp_q.size() || obs_q.size() < 4 || obs_q[0].pc1 !== 64'h1000) begin n_bad++;
            $display("FAIL fill_stream_count: got %0d pairs, expected %0d (at least 4, first at 1000)", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
            if (o !== e) begin n_bad++;
                $display("FAIL fill_stream_pair: got %h %h %h %h, expected %h %h %h %h", o.pc1, o.i1, o.i2, o.pc2, e.pc1, e.i1, e.i2, e.pc2); end
        end
    endtask

    task automatic test_redirect_wait();
        int k = 0;
        do_reset(1'b0, 1'b1, 3);
        tick(); tick();
        PCSrcE1 = 1'b1; PCSrcE2 = 1'b1; PCTargetE1 = 64'h2004; PCTargetE2 = 64'h3000;
        sb_skip = 1; next_unaligned = 1; lat = 1;
        tick();
        PCSrcE1 = 1'b0; PCSrcE2 = 1'b0;
        while (ic_req_valid !== 1'b1 && k < 20) begin tick(); k++; end
        n_cmp++; if (ic_req_valid !== 1'b1 || ic_req_addr !== 64'h2000) begin n_bad++;
            $display("FAIL redirect_req: valid=%b addr=%h, expected 1 / 2000", ic_req_valid, ic_req_addr); end
        k = 0;
        while (ic_req_valid !== 1'b0 && k < 20) begin tick(); k++; end
        while (ic_req_valid !== 1'b1 && k < 40) begin tick(); k++; end
        n_cmp++; if (ic_req_valid !== 1'b1 || ic_req_addr !== 64'h2008) begin n_bad++;
            $display("FAIL redirect_next_req: valid=%b addr=%h, expected 1 / 2008", ic_req_valid, ic_req_addr); end
        ic_req_ready = 1'b0;
        repeat (12) tick();
        n_cmp++; if (obs_q.size() != exp_q.size() || obs_q.size() == 0 || obs_q[0].pc1 !== 64'h2004) begin n_bad++;
            $display("FAIL redir_stream_count: got %0d pairs, expected %0d (first at 2004)", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
            if (o !== e) begin n_bad++;
                $display("FAIL redir_stream_pair: got %h %h %h %h, expected %h %h %h %h", o.pc1, o.i1, o.i2, o.pc2, e.pc1, e.i1, e.i2, e.pc2); end
        end
    endtask

    task automatic test_redirect_resp();
        int k = 0;
        do_reset(1'b1, 1'b1, 1);
        while (exp_q.size() < 2 && k < 40) begin tick(); k++; end
        n_cmp++; if (ic_resp_valid !== 1'b1 || exp_q.size() != 2) begin n_bad++;
            $display("FAIL resp_setup: resp_valid=%b responses=%0d, expected 1 / 2", ic_resp_valid, exp_q.size()); end
        PCSrcE1 = 1'b1; PCTargetE1 = 64'h4000;
        exp_q.delete();
        tick();
        PCSrcE1 = 1'b0;
        n_cmp++; if (ic_req_valid !== 1'b0) begin n_bad++;
            $display("FAIL resp_redirect_idle: valid=%b, expected 0", ic_req_valid); end
        tick();
        n_cmp++; if (ic_req_valid !== 1'b1 || ic_req_addr !== 64'h4000) begin n_bad++;
            $display("FAIL resp_redirect_req: valid=%b addr=%h, expected 1 / 4000", ic_req_valid, ic_req_addr); end
        StallD = 1'b0;
        repeat (10) tick();
        ic_req_ready = 1'b0;
        repeat (12) tick();
        n_cmp++; if (obs_q.size() != exp_q.size() || obs_q.size() == 0 || obs_q[0].pc1 !== 64'h4000) begin n_bad++;
            $display("FAIL resp_stream_count: got %0d pairs, expected %0d (first at 4000)", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
            if (o !== e) begin n_bad++;
                $display("FAIL resp_stream_pair: got %h %h %h %h, expected %h %h %h %h", o.pc1, o.i1, o.i2, o.pc2, e.pc1, e.i1, e.i2, e.pc2); end
        end
    endtask

    task automatic test_flush_stall();
        int k = 0;
        do_reset(1'b0, 1'b1, 1);
        while (enableD !== 1'b1 && k < 20) begin tick(); k++; end
        FlushD = 1'b1; StallD = 1'b1;
        tick();
        n_cmp++; if (enableD !== 1'b0 || InstrD1 !== NOP_INSTR || InstrD2 !== NOP_INSTR) begin n_bad++;
            $display("FAIL flush_over_stall: en=%b i1=%h i2=%h, expected 0 / 00000013 / 00000013", enableD, InstrD1, InstrD2); end
        FlushD = 1'b0; StallD = 1'b0;
        repeat (8) tick();
        ic_req_ready = 1'b0;
        repeat (12) tick();
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++;
            $display("FAIL flush_stream_count: got %0d pairs, expected %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
            if (o !== e) begin n_bad++;
                $display("FAIL flush_stream_pair: got %h %h %h %h, expected %h %h %h %h", o.pc1, o.i1, o.i2, o.pc2, e.pc1, e.i1, e.i2, e.pc2); end
        end
    endtask

    task automatic test_reset_async();
        int k = 0;
        do_reset(1'b0, 1'b1, 1);
        while (!(enableD === 1'b1 && ic_req_valid === 1'b1) && k < 20) begin tick(); k++; end
        StallD = 1'b1;
        tick();
        n_cmp++; if (enableD !== 1'b1 || PCD1 !== 64'h1000 || ic_req_addr !== 64'h1008) begin n_bad++;
            $display("FAIL async_setup: en=%b pcd1=%h addr=%h, expected 1 / 1000 / 1008", enableD, PCD1, ic_req_addr); end
        #1 reset = 1'b1;
        #1;
        n_cmp++; if (ic_req_valid !== 1'b0 || ic_req_addr !== 64'h1000) begin n_bad++;
            $display("FAIL async_req: valid=%b addr=%h, expected 0 / 1000", ic_req_valid, ic_req_addr); end
        n_cmp++; if (enableD !== 1'b0 || InstrD1 !== NOP_INSTR || InstrD2 !== NOP_INSTR || PCD1 !== 64'h0 || PCD2 !== 64'h4) begin n_bad++;
            $display("FAIL async_dec: en=%b i1=%h i2=%h pcd1=%h pcd2=%h, expected 0 00000013 00000013 0 4", enableD, InstrD1, InstrD2, PCD1, PCD2); end
        tick();
    endtask

    initial begin
        reset = 1'b1; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
        PCSrcE1 = 1'b0; PCSrcE2 = 1'b0; PCTargetE1 = '0; PCTargetE2 = '0; ic_req_ready = 1'b0;
        test_reset();
        test_first_fetch();
        test_ready_hold();
        test_stall_fill();
        test_redirect_wait();
        test_redirect_resp();
        test_flush_stall();
        test_reset_async();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
